// File: rtl/mem_req_ctrl.sv
// Processor-side memory request initiator: issues one load/store to the memory
// system, holds it until Done, error or timeout, then returns a one-cycle response.
module mem_req_ctrl #(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic             req_wr,
  input  logic [15:0]      req_addr,
  input  logic [15:0]      req_wdata,
  output logic             pipe_stall,
  output logic             rsp_valid,
  output logic [15:0]      rsp_rdata,
  output logic             rsp_err,
  output logic [15:0]      Addr,
  output logic [15:0]      DataIn,
  output logic             Rd,
  output logic             Wr,
  input  logic [15:0]      DataOut,
  input  logic             Done,
  input  logic             Stall,
  input  logic             CacheHit,
  input  logic             err,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  state_t           state;
  state_t           state_nxt;
  logic [15:0]      addr_q;
  logic [15:0]      wdata_q;
  logic             wr_q;
  logic [15:0]      rdata_q;
  logic             err_q;
  logic [TMR_W-1:0] timer;
  logic             timed_out;
  logic             stall_unused;

  // Stall is purely informational: completion is decided by Done alone.
  assign stall_unused = Stall;

  assign timed_out = (state == BUSY) && !Done && (timer == TMR_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_nxt = req_addr[0] ? RESP : BUSY;
        end
      end
      BUSY: begin
        if (Done || err || timed_out) begin
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Rd/Wr come only from the state register and the latched direction, so
  // the memory-side strobes never see a combinational path from Done.
  always_comb begin
    pipe_stall = ((state == IDLE) && req_valid) || (state == BUSY);
    Rd         = (state == BUSY) && !wr_q;
    Wr         = (state == BUSY) && wr_q;
    rsp_valid  = (state == RESP);
    rsp_err    = (state == RESP) && err_q;
    rsp_rdata  = (state == RESP) ? rdata_q : 16'h0000;
  end

  assign Addr   = addr_q;
  assign DataIn = wdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      wr_q    <= 1'b0;
      rdata_q <= 16'h0000;
      err_q   <= 1'b0;
      timer   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && !req_addr[0]) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wr_q    <= req_wr;
            rdata_q <= 16'h0000;
            err_q   <= 1'b0;
            timer   <= '0;
          end else if (req_valid) begin
            rdata_q <= 16'h0000;
            err_q   <= 1'b1;
          end
        end
        BUSY: begin
          if (Done) begin
            rdata_q <= wr_q ? 16'h0000 : DataOut;
            err_q   <= err;
          end else if (err || timed_out) begin
            err_q   <= 1'b1;
          end else begin
            timer   <= timer + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Statistics only count completions seen in BUSY and stick at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if ((state == BUSY) && Done) begin
      if (CacheHit) begin
        if (hit_cnt != {CNT_W{1'b1}}) hit_cnt <= hit_cnt + 1'b1;
      end else begin
        if (miss_cnt != {CNT_W{1'b1}}) miss_cnt <= miss_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed self-checking bench for mem_req_ctrl; counters narrowed to 2 bits so
// saturation is reachable in a few transactions.
module tb_mem_req_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_wr = 1'b0;
  logic [15:0] req_addr = 16'h0000;
  logic [15:0] req_wdata = 16'h0000;
  logic        pipe_stall;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic [15:0] Addr;
  logic [15:0] DataIn;
  logic        Rd;
  logic        Wr;
  logic [15:0] DataOut = 16'h0000;
  logic        Done = 1'b0;
  logic        Stall = 1'b0;
  logic        CacheHit = 1'b0;
  logic        err = 1'b0;
  logic [1:0]  hit_cnt;
  logic [1:0]  miss_cnt;

  int tests  = 0;
  int errors = 0;

  mem_req_ctrl #(.TIMEOUT(256), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .pipe_stall(pipe_stall),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr), .DataOut(DataOut),
    .Done(Done), .Stall(Stall), .CacheHit(CacheHit), .err(err),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    #1;
    tests++; if (Rd !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd: got %b expected 0", Rd); end
    tests++; if (Wr !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr: got %b expected 0", Wr); end
    tests++; if (pipe_stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall: got %b expected 0", pipe_stall); end
    tests++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp: got %b%b expected 00", rsp_valid, rsp_err); end
    tests++; if (Addr !== 16'h0000 || DataIn !== 16'h0000) begin errors++; $display("[TB] FAIL reset_bus: got %h/%h expected 0000/0000", Addr, DataIn); end
    tests++; if (hit_cnt !== 2'd0 || miss_cnt !== 2'd0) begin errors++; $display("[TB] FAIL reset_cnt: got %0d/%0d expected 0/0", hit_cnt, miss_cnt); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_load_hit();
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 16'h0010;
    #1;
    tests++; if (pipe_stall !== 1'b1) begin errors++; $display("[TB] FAIL lh_issue_stall: got %b expected 1", pipe_stall); end
    tests++; if (Rd !== 1'b0) begin errors++; $display("[TB] FAIL lh_issue_rd: got %b expected 0", Rd); end
    tick();
    Done = 1'b1; CacheHit = 1'b1; DataOut = 16'hBEEF;
    #1;
    tests++; if (Rd !== 1'b1 || Wr !== 1'b0) begin errors++; $display("[TB] FAIL lh_busy_rdwr: got %b%b expected 10", Rd, Wr); end
    tests++; if (Addr !== 16'h0010) begin errors++; $display("[TB] FAIL lh_addr: got %h expected 0010", Addr); end
    tick();
    Done = 1'b0; CacheHit = 1'b0; req_valid = 1'b0;
    #1;
    tests++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL lh_rsp: got %b%b expected 10", rsp_valid, rsp_err); end
    tests++; if (rsp_rdata !== 16'hBEEF) begin errors++; $display("[TB] FAIL lh_rdata: got %h expected beef", rsp_rdata); end
    tests++; if (hit_cnt !== 2'd1) begin errors++; $display("[TB] FAIL lh_hitcnt: got %0d expected 1", hit_cnt); end
    tests++; if (pipe_stall !== 1'b0 || Rd !== 1'b0) begin errors++; $display("[TB] FAIL lh_resp_idle: got %b%b expected 00", pipe_stall, Rd); end
    tick();
    #1;
    tests++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL lh_pulse: got %b expected 0", rsp_valid); end
  endtask

  task automatic test_store_miss();
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 16'h0020; req_wdata = 16'h1234;
    #1;
    tests++; if (pipe_stall !== 1'b1) begin errors++; $display("[TB] FAIL sm_issue_stall: got %b expected 1", pipe_stall); end
    tick();
    for (int i = 0; i < 5; i++) begin
      Stall = 1'b1;
      #1;
      tests++;
      if (Wr !== 1'b1 || Rd !== 1'b0 || DataIn !== 16'h1234 || Addr !== 16'h0020) begin
        errors++;
        $display("[TB] FAIL sm_hold[%0d]: got Wr=%b Rd=%b DataIn=%h Addr=%h expected 1 0 1234 0020", i, Wr, Rd, DataIn, Addr);
      end
      tick();
    end
    Stall = 1'b0; Done = 1'b1; CacheHit = 1'b0;
    tick();
    Done = 1'b0; req_valid = 1'b0; req_wr = 1'b0;
    #1;
    tests++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL sm_rsp: got %b%b expected 10", rsp_valid, rsp_err); end
    tests++; if (rsp_rdata !== 16'h0000) begin errors++; $display("[TB] FAIL sm_rdata: got %h expected 0000", rsp_rdata); end
    tests++; if (miss_cnt !== 2'd1 || hit_cnt !== 2'd1) begin errors++; $display("[TB] FAIL sm_cnt: got %0d/%0d expected 1/1", hit_cnt, miss_cnt); end
    tick();
  endtask

  task automatic test_misaligned();
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 16'h0003;
    #1;
    tests++; if (pipe_stall !== 1'b1 || Rd !== 1'b0 || Wr !== 1'b0) begin errors++; $display("[TB] FAIL mis_issue: got stall=%b Rd=%b Wr=%b expected 1 0 0", pipe_stall, Rd, Wr); end
    tick();
    req_valid = 1'b0;
    #1;
    tests++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin errors++; $display("[TB] FAIL mis_rsp: got %b%b expected 11", rsp_valid, rsp_err); end
    tests++; if (Rd !== 1'b0 || Wr !== 1'b0) begin errors++; $display("[TB] FAIL mis_rdwr: got %b%b expected 00", Rd, Wr); end
    tick();
    #1;
    tests++; if (rsp_valid !== 1'b0 || hit_cnt !== 2'd1 || miss_cnt !== 2'd1) begin errors++; $display("[TB] FAIL mis_after: got v=%b %0d/%0d expected 0 1/1", rsp_valid, hit_cnt, miss_cnt); end
  endtask

  task automatic test_mem_err();
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 16'h0030;
    tick();
    err = 1'b1;
    tick();
    err = 1'b0; req_valid = 1'b0;
    #1;
    tests++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin errors++; $display("[TB] FAIL err_rsp: got %b%b expected 11", rsp_valid, rsp_err); end
    tests++; if (hit_cnt !== 2'd1 || miss_cnt !== 2'd1) begin errors++; $display("[TB] FAIL err_cnt: got %0d/%0d expected 1/1", hit_cnt, miss_cnt); end
    tick();
  endtask

  task automatic test_done_idle();
    Done = 1'b1; CacheHit = 1'b1;
    tick();
    tick();
    Done = 1'b0; CacheHit = 1'b0;
    #1;
    tests++; if (hit_cnt !== 2'd1 || miss_cnt !== 2'd1 || rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL done_idle: got %0d/%0d v=%b expected 1/1 0", hit_cnt, miss_cnt, rsp_valid); end
  endtask

  task automatic test_timeout();
    int rd_cycles;
    bit seen;
    bit err_seen;
    rd_cycles = 0; seen = 1'b0; err_seen = 1'b0;
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 16'h0040;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 400; i++) begin
      #1;
      if (rsp_valid === 1'b1) begin
        seen = 1'b1;
        err_seen = rsp_err;
        break;
      end
      if (Rd === 1'b1) rd_cycles++;
      tick();
    end
    tests++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL to_rsp: got %b expected 1 within 400 cycles", seen); end
    tests++; if (rd_cycles != 256) begin errors++; $display("[TB] FAIL to_rd_cycles: got %0d expected 256", rd_cycles); end
    tests++; if (err_seen !== 1'b1 || Rd !== 1'b0) begin errors++; $display("[TB] FAIL to_err: got err=%b Rd=%b expected 1 0", err_seen, Rd); end
    tick();
  endtask

  task automatic test_saturation();
    logic [1:0] exp_hits [3];
    exp_hits[0] = 2'd2; exp_hits[1] = 2'd3; exp_hits[2] = 2'd3;
    for (int k = 0; k < 3; k++) begin
      req_valid = 1'b1; req_wr = 1'b0; req_addr = 16'h0100;
      tick();
      Done = 1'b1; CacheHit = 1'b1; DataOut = 16'h00A5;
      tick();
      Done = 1'b0; CacheHit = 1'b0; req_valid = 1'b0;
      #1;
      tests++; if (hit_cnt !== exp_hits[k]) begin errors++; $display("[TB] FAIL sat_hit[%0d]: got %0d expected %0d", k, hit_cnt, exp_hits[k]); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int rsps;
    rsps = 0;
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 16'h0050;
    tick();
    Done = 1'b1; CacheHit = 1'b0; DataOut = 16'h1111;
    #1;
    tests++; if (Addr !== 16'h0050) begin errors++; $display("[TB] FAIL b2b_addr0: got %h expected 0050", Addr); end
    tick();
    Done = 1'b0; req_addr = 16'h0052;
    #1;
    if (rsp_valid === 1'b1) rsps++;
    tests++; if (rsp_rdata !== 16'h1111 || pipe_stall !== 1'b0) begin errors++; $display("[TB] FAIL b2b_rsp0: got %h stall=%b expected 1111 0", rsp_rdata, pipe_stall); end
    tick();
    #1;
    if (rsp_valid === 1'b1) rsps++;
    tests++; if (pipe_stall !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_gap: got stall=%b v=%b expected 1 0", pipe_stall, rsp_valid); end
    tick();
    Done = 1'b1; DataOut = 16'h2222;
    #1;
    tests++; if (Addr !== 16'h0052 || Rd !== 1'b1) begin errors++; $display("[TB] FAIL b2b_addr1: got %h Rd=%b expected 0052 1", Addr, Rd); end
    tick();
    Done = 1'b0; req_valid = 1'b0;
    #1;
    if (rsp_valid === 1'b1) rsps++;
    tests++; if (rsp_rdata !== 16'h2222 || miss_cnt !== 2'd3) begin errors++; $display("[TB] FAIL b2b_rsp1: got %h miss=%0d expected 2222 3", rsp_rdata, miss_cnt); end
    tests++; if (rsps != 2) begin errors++; $display("[TB] FAIL b2b_count: got %0d expected 2", rsps); end
    tick();
  endtask

  task automatic test_reset_mid_busy();
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 16'h0060;
    tick();
    #1;
    tests++; if (Rd !== 1'b1) begin errors++; $display("[TB] FAIL rmb_busy: got %b expected 1", Rd); end
    rst = 1'b1;
    tick();
    rst = 1'b0; req_valid = 1'b0;
    #1;
    tests++; if (Rd !== 1'b0 || pipe_stall !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL rmb_outs: got Rd=%b stall=%b v=%b expected 0 0 0", Rd, pipe_stall, rsp_valid); end
    tests++; if (hit_cnt !== 2'd0 || miss_cnt !== 2'd0) begin errors++; $display("[TB] FAIL rmb_cnt: got %0d/%0d expected 0/0", hit_cnt, miss_cnt); end
    tick();
  endtask

  initial begin
    test_reset();
    test_load_hit();
    test_store_miss();
    test_misaligned();
    test_mem_err();
    test_done_idle();
    test_timeout();
    test_saturation();
    test_back_to_back();
    test_reset_mid_busy();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
